apb_cmd_master: RTL and testbench
=================================

# apb_cmd_master

Command-driven APB master that generates the PSEL/PENABLE/PADDR/PWDATA/PWRITE sequence for the GPIO peripheral. It sits directly upstream of the GPIO block and replaces hand-driven bus stimulus with a protocol-correct two-phase SETUP/ACCESS engine. A small command FIFO decouples the issuing logic, and read data is returned on a one-cycle response strobe.

## Interface
- ADDR_W, 3, APB address width; matches the GPIO register map: 0 dir, 1 set, 2 clr, 4 status.
- DATA_W, 8, APB data width.
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2.
- TIMEOUT, 16, maximum ACCESS wait cycles. Used only with APB_MASTER_TIMEOUT_EN.

Ports:
- PCLK  in  1  sole clock; all state updates on its rising edge.
- PRESETn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target register.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  one-cycle completion strobe; no backpressure.
- rsp_rdata  out  DATA_W  PRDATA captured for reads; 0 for writes.
- rsp_err  out  1  timeout flag; constant 0 when the macro is absent.
- busy  out  1  FIFO non-empty or state ≠ IDLE.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  slave ready; tie to 1 for slaves without wait states (GPIO).

## Operation
- Command accept: on a rising edge where cmd_valid && cmd_ready, the command is pushed into the FIFO.
- cmd_ready = !full, evaluated before any same-edge pop. A push while full is refused even if a pop occurs on that edge.
- FSM states:
  - IDLE: PSEL=0, PENABLE=0. If FIFO non-empty, pop the head, load PADDR/PWDATA/PWRITE, and go to SETUP.
  - SETUP: PSEL=1, PENABLE=0. Unconditionally go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. If PREADY=1, complete the transfer:
    - FIFO non-empty: pop the next command and go to SETUP with PSEL held high (back-to-back).
    - FIFO empty: go to IDLE.
  - ACCESS with PREADY=0: stay in ACCESS; all bus outputs held stable.
- Completion: rsp_valid=1 for exactly one cycle after the completing edge.
  - Read: rsp_rdata = PRDATA sampled at that edge.
  - Write: rsp_rdata = 0.
- PADDR/PWDATA/PWRITE hold their last values in IDLE. PWDATA loads 0 for reads.
- All outputs are registered. There is no combinational path from cmd_* or PREADY to the bus outputs.
- FIFO pointers wrap modulo FIFO_DEPTH; the count width is log2(FIFO_DEPTH)+1.

## Timing
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, cmd_ready=1. FIFO is empty; state is IDLE.
- Reset mid-transfer: on the next edge all of the above take effect. The FIFO is flushed and no response is issued for the aborted or queued commands.
- Command accepted at edge k with the FSM idle:
  - PSEL=1 after edge k+1.
  - PENABLE=1 after edge k+2.
  - With PREADY=1, completion at edge k+3 and rsp_valid high during cycle k+3..k+4.
- Back-to-back throughput: 2 cycles per transfer.
- Each PREADY=0 ACCESS cycle adds one cycle of latency.
- busy is registered; it rises the cycle after the first accept and falls after the final completion with the FIFO empty.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A wait counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT, the transfer is forced complete: rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - The FSM then proceeds exactly as on a normal completion.
- APB_MASTER_TIMEOUT_EN undefined:
  - No counter. The FSM waits in ACCESS indefinitely.
  - rsp_err is tied to 0 and TIMEOUT is unused.

## Test plan
- Reset, then single write {addr 0, data 0x01}, PREADY=1 → PSEL at k+1, PENABLE at k+2, PADDR=0, PWDATA=0x01, PWRITE=1; rsp_valid pulse with rsp_rdata=0.
- Push 3 writes back-to-back: {0, 0x03}, {1, 0x03}, {2, 0x02} → PSEL stays high throughout; three SETUP/ACCESS pairs in 6 cycles; three rsp_valid pulses; busy falls after the third.
- Read {addr 4} with PRDATA=0xA5, PREADY=1 → PWRITE=0, PWDATA=0; rsp_rdata=0xA5 on the rsp_valid cycle.
- Hold cmd_valid with PREADY=0 until FIFO_DEPTH=4 commands are queued plus one in flight → cmd_ready=0 and the fifth push is refused; after PREADY=1 all queued commands complete in order.
- PREADY=0 for 20 cycles:
  - Macro on, TIMEOUT=16: completion after 16 wait cycles with rsp_err=1, rsp_rdata=0.
  - Macro off: bus outputs remain stable for all 20 cycles, then the transfer completes normally.
- Assert PRESETn=0 during ACCESS with 2 commands queued → next edge PSEL=PENABLE=0, busy=0, no rsp_valid; after release the bus stays idle.

Source files
------------

// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if: command/response and APB bus signals of the command-driven APB master
interface apb_cmd_master_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: FIFO-fed APB SETUP/ACCESS engine; define APB_MASTER_TIMEOUT_EN for the ACCESS wait timeout
module apb_cmd_master #(
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input logic                PCLK,
    input logic                PRESETn,
    apb_cmd_master_if.master   bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic [PW:0]       r_cnt;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_done;
    logic              w_to;
    logic [CW-1:0]     w_head;

    assign w_full  = r_cnt == (PW+1)'(FIFO_DEPTH);
    assign w_empty = r_cnt == '0;
    assign w_push  = bus.cmd_valid && !w_full;
    assign w_head  = r_mem[r_rp];

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_wait;
    // the transfer is abandoned on the ACCESS edge that would bring the wait count to TIMEOUT
    assign w_to = r_state == ACCESS && !bus.PREADY && r_wait == TW'(TIMEOUT - 1);
    // wait counter: cleared while entering ACCESS, counts stalled ACCESS cycles
    always_ff @(posedge PCLK) begin
        if (!PRESETn)
            r_wait <= '0;
        else if (r_state == SETUP)
            r_wait <= '0;
        else if (r_state == ACCESS && !bus.PREADY)
            r_wait <= r_wait + 1'b1;
    end
`else
    assign w_to = 1'b0;
`endif

    // state register
    always_ff @(posedge PCLK) begin
        if (!PRESETn)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // next state, FIFO pop and transfer completion
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: begin
                w_pop  = !w_empty;
                w_next = w_empty ? IDLE : SETUP;
            end
            SETUP: w_next = ACCESS;
            ACCESS: begin
                if (bus.PREADY || w_to) begin
                    w_done = 1'b1;
                    w_pop  = !w_empty;
                    w_next = w_empty ? IDLE : SETUP;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // FIFO pointers and occupancy; full blocks a push even when a pop happens on the same edge
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    // FIFO storage: {write, addr, wdata}
    always_ff @(posedge PCLK) begin
        if (w_push)
            r_mem[r_wp] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    end

    // bus address/data/direction load on pop and hold otherwise; reads drive zero write data
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else if (w_pop) begin
            r_pwrite <= w_head[CW-1];
            r_paddr  <= w_head[CW-2 -: ADDR_W];
            r_pwdata <= w_head[CW-1] ? w_head[DATA_W-1:0] : '0;
        end
    end

    // one-cycle response strobe; data only for reads that really completed
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_done;
            r_rsp_rdata <= (w_done && !w_to && !r_pwrite) ? bus.PRDATA : '0;
            r_rsp_err   <= w_to;
        end
    end

    assign bus.cmd_ready = !w_full;
    assign bus.busy      = !w_empty || r_state != IDLE;
    assign bus.PSEL      = r_state != IDLE;
    assign bus.PENABLE   = r_state == ACCESS;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed bench for apb_cmd_master (timeout checks follow APB_MASTER_TIMEOUT_EN)
module tb_apb_cmd_master;
    logic clk = 1'b0;
    logic rstn;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [11:0] xfer_q[$];
    logic [8:0]  rsp_q[$];

    always #5 clk = ~clk;

    apb_cmd_master_if bus();
    apb_cmd_master dut (.PCLK(clk), .PRESETn(rstn), .bus(bus));

    // log completed APB transfers {PWRITE,PADDR,PWDATA} and responses {err,rdata}
    always @(negedge clk) begin
        if (bus.PSEL && bus.PENABLE && bus.PREADY)
            xfer_q.push_back({bus.PWRITE, bus.PADDR, bus.PWDATA});
        if (bus.rsp_valid)
            rsp_q.push_back({bus.rsp_err, bus.rsp_rdata});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic w, input logic [2:0] a, input logic [7:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 50 && bus.busy; i++)
            tick();
        chk("idle", bus.busy, 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int hi;
        int n;
        int idx;
        int hit;
        int unstable;
        logic rdy;
        logic [13:0] snap;
        rstn = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.PREADY    = 1'b1;
        bus.PRDATA    = '0;
        tick();
        tick();
        chk("rst_psel", bus.PSEL, 0);
        chk("rst_penable", bus.PENABLE, 0);
        chk("rst_pwrite", bus.PWRITE, 0);
        chk("rst_paddr", bus.PADDR, 0);
        chk("rst_pwdata", bus.PWDATA, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        rstn = 1'b1;
        tick();

        // single write {0, 0x01}
        xfer_q.delete();
        rsp_q.delete();
        push(1'b1, 3'd0, 8'h01);
        chk("w1_busy_k", bus.busy, 1);
        chk("w1_psel_k", bus.PSEL, 0);
        tick();
        chk("w1_psel_k1", bus.PSEL, 1);
        chk("w1_pen_k1", bus.PENABLE, 0);
        chk("w1_paddr", bus.PADDR, 0);
        chk("w1_pwdata", bus.PWDATA, 8'h01);
        chk("w1_pwrite", bus.PWRITE, 1);
        tick();
        chk("w1_pen_k2", bus.PENABLE, 1);
        chk("w1_rspv_k2", bus.rsp_valid, 0);
        tick();
        chk("w1_rspv_k3", bus.rsp_valid, 1);
        chk("w1_rdata", bus.rsp_rdata, 0);
        chk("w1_psel_k3", bus.PSEL, 0);
        chk("w1_busy_k3", bus.busy, 0);
        tick();
        chk("w1_rspv_k4", bus.rsp_valid, 0);
        chk("w1_nrsp", rsp_q.size(), 1);
        chk("w1_xfer", xfer_q[0], 12'h801);

        // three back-to-back writes
        xfer_q.delete();
        rsp_q.delete();
        hi = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr = 3'd0; bus.cmd_wdata = 8'h03; tick(); if (bus.PSEL) hi++;
        bus.cmd_addr = 3'd1; bus.cmd_wdata = 8'h03; tick(); if (bus.PSEL) hi++;
        bus.cmd_addr = 3'd2; bus.cmd_wdata = 8'h02; tick(); if (bus.PSEL) hi++;
        bus.cmd_valid = 1'b0;
        n = 0;
        while (bus.busy && n < 20) begin
            tick();
            n++;
            if (bus.PSEL) hi++;
        end
        chk("b2b_psel_cycles", hi, 6);
        chk("b2b_drain_cycles", n, 5);
        chk("b2b_busy", bus.busy, 0);
        tick();
        chk("b2b_nrsp", rsp_q.size(), 3);
        chk("b2b_xfer0", xfer_q[0], 12'h803);
        chk("b2b_xfer1", xfer_q[1], 12'h903);
        chk("b2b_xfer2", xfer_q[2], 12'hA02);

        // read from status register
        xfer_q.delete();
        rsp_q.delete();
        bus.PRDATA = 8'hA5;
        push(1'b0, 3'd4, 8'h77);
        tick();
        chk("rd_pwrite", bus.PWRITE, 0);
        chk("rd_pwdata", bus.PWDATA, 0);
        chk("rd_paddr", bus.PADDR, 4);
        wait_idle();
        chk("rd_nrsp", rsp_q.size(), 1);
        chk("rd_rsp", rsp_q[0], 9'h0A5);

        // fill the FIFO while the slave stalls
        xfer_q.delete();
        rsp_q.delete();
        bus.PREADY = 1'b0;
        bus.PRDATA = 8'h3C;
        idx = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        for (int t = 0; t < 8; t++) begin
            bus.cmd_addr  = 3'(idx);
            bus.cmd_wdata = 8'(8'h10 + idx);
            rdy = bus.cmd_ready;
            tick();
            if (rdy) idx++;
        end
        chk("fill_accepted", idx, 5);
        chk("fill_ready", bus.cmd_ready, 0);
        chk("fill_stalled", bus.PENABLE, 1);
        bus.PREADY = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        chk("full_pop_ready", bus.cmd_ready, 1);
        wait_idle();
        chk("fill_nxfer", xfer_q.size(), 5);
        chk("fill_nrsp", rsp_q.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("fill_order", xfer_q[i], {1'b1, 3'(i), 8'(8'h10 + i)});

        // 20 stalled ACCESS cycles
        xfer_q.delete();
        rsp_q.delete();
        bus.PREADY = 1'b0;
        push(1'b1, 3'd2, 8'h5A);
        tick();
        tick();
        chk("wait_access", bus.PENABLE, 1);
        snap = {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA};
        hit = 0;
        unstable = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (bus.rsp_valid && hit == 0) hit = t;
            if (hit == 0 && snap !== {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}) unstable++;
        end
        chk("wait_stable", unstable, 0);
`ifdef APB_MASTER_TIMEOUT_EN
        chk("to_cycle", hit, 16);
        chk("to_rsp", rsp_q[0], 9'h100);
        bus.PREADY = 1'b1;
        wait_idle();
        chk("to_nrsp", rsp_q.size(), 1);
`else
        chk("wait_no_rsp", hit, 0);
        bus.PREADY = 1'b1;
        tick();
        chk("wait_done", bus.rsp_valid, 1);
        chk("wait_err", bus.rsp_err, 0);
        wait_idle();
        chk("wait_nxfer", xfer_q.size(), 1);
        chk("wait_xfer", xfer_q[0], 12'hA5A);
`endif

        // reset during ACCESS with two commands queued
        xfer_q.delete();
        rsp_q.delete();
        bus.PREADY = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.cmd_addr  = 3'(i + 1);
            bus.cmd_wdata = 8'(8'hC0 + i);
            tick();
        end
        bus.cmd_valid = 1'b0;
        chk("mid_access", bus.PENABLE, 1);
        rstn = 1'b0;
        tick();
        chk("mid_psel", bus.PSEL, 0);
        chk("mid_penable", bus.PENABLE, 0);
        chk("mid_busy", bus.busy, 0);
        chk("mid_rspv", bus.rsp_valid, 0);
        chk("mid_ready", bus.cmd_ready, 1);
        chk("mid_paddr", bus.PADDR, 0);
        rstn = 1'b1;
        bus.PREADY = 1'b1;
        hi = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (bus.PSEL || bus.busy) hi++;
        end
        chk("post_rst_idle", hi, 0);
        chk("post_rst_nrsp", rsp_q.size(), 0);
        chk("post_rst_nxfer", xfer_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
